// File: rtl/flt2int_conv_seq.sv
// Sequential float-to-integer converter with a valid/ready handshake on both sides.
// The operand is decoded, then its restored significand is shifted one bit per
// cycle into place. The result is a saturating sign-magnitude integer.
// Optional feature: define FLT2INT_ROUND_EN for round-to-nearest-even.
// Without it the result is truncated toward zero.
module flt2int_conv_seq #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned INT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_flt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INT_W-1:0]       out_int,
    output logic                   out_ovf
);

    // The shifter is wide enough for the significand and for the integer magnitude.
    localparam int unsigned ShW  = (INT_W - 1 > MAN_W + 1) ? INT_W - 1 : MAN_W + 1;
    localparam int unsigned CntW = $clog2(INT_W + MAN_W + 4);
    localparam int          Bias = (2 ** (EXP_W - 1)) - 1;
    localparam int          MaxE = int'(INT_W) - 2;
    localparam int          ManW = int'(MAN_W);

    typedef enum logic [2:0] {StIdle, StCalc, StShift, StFix, StDone} state_e;
    typedef enum logic [1:0] {ClsNorm, ClsZero, ClsSat} cls_e;

    state_e                 state_q, state_d;
    logic [EXP_W+MAN_W:0]   flt_q;
    cls_e                   cls_q;
    logic                   dir_left_q;
    logic [CntW-1:0]        cnt_q;
    logic [ShW-1:0]         sh_q;
    logic [INT_W-1:0]       out_int_q;
    logic                   out_ovf_q;

    logic [EXP_W-1:0]       exp_f;
    logic [MAN_W-1:0]       mant_f;
    int                     e_c;
    cls_e                   cls_c;
    logic                   dir_left_c;
    logic [CntW-1:0]        cnt_c;
    logic [ShW-1:0]         sig_c;

    logic [INT_W-2:0]       mag_c;
    logic                   round_up_c;
    logic [INT_W-1:0]       sum_c;
    logic [INT_W-2:0]       mag_fix_c;
    logic                   ovf_fix_c;
    logic [INT_W-1:0]       int_fix_c;

    assign exp_f  = flt_q[MAN_W +: EXP_W];
    assign mant_f = flt_q[MAN_W-1:0];

    // Decode the latched operand: class, shift direction and shift count.
    always_comb begin
        e_c        = int'(exp_f) - Bias;
        cls_c      = ClsNorm;
        dir_left_c = 1'b0;
        cnt_c      = '0;
        sig_c      = '0;
        if (exp_f == '0) begin
            cls_c = ClsZero;
        end else if ((&exp_f) || (e_c > MaxE)) begin
            cls_c = ClsSat;
        end else begin
            sig_c = ShW'({1'b1, mant_f});
            if (e_c >= ManW) begin
                dir_left_c = 1'b1;
                cnt_c      = CntW'(e_c - ManW);
            end else if (ManW - e_c > ManW + 2) begin
                // Beyond this every significand bit has already left the window.
                cnt_c = CntW'(ManW + 2);
            end else begin
                cnt_c = CntW'(ManW - e_c);
            end
        end
    end

`ifdef FLT2INT_ROUND_EN
    logic guard_q, sticky_q;

    // Track the last bit shifted out and the OR of every bit before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (state_q == StCalc) begin
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if ((state_q == StShift) && !dir_left_q) begin
            guard_q  <= sh_q[0];
            sticky_q <= sticky_q | guard_q;
        end
    end

    assign round_up_c = guard_q & (sticky_q | mag_c[0]);
`else
    assign round_up_c = 1'b0;
`endif

    // Final result: rounding, saturation and the no-negative-zero rule.
    always_comb begin
        mag_c     = sh_q[INT_W-2:0];
        sum_c     = {1'b0, mag_c} + INT_W'(round_up_c);
        mag_fix_c = sum_c[INT_W-2:0];
        ovf_fix_c = 1'b0;
        if ((cls_q == ClsSat) || sum_c[INT_W-1]) begin
            mag_fix_c = '1;
            ovf_fix_c = 1'b1;
        end
        int_fix_c = {flt_q[EXP_W+MAN_W] & (|mag_fix_c), mag_fix_c};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a conversion with nothing to shift goes straight to FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StCalc;
            StCalc:  begin
                if ((cls_c != ClsNorm) || (cnt_c == '0)) begin
                    state_d = StFix;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: if (cnt_q == CntW'(1)) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers, each updated only in the state that owns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_q      <= '0;
            cls_q      <= ClsNorm;
            dir_left_q <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            out_int_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) flt_q <= in_flt;
                end
                StCalc: begin
                    cls_q      <= cls_c;
                    dir_left_q <= dir_left_c;
                    cnt_q      <= cnt_c;
                    sh_q       <= sig_c;
                end
                StShift: begin
                    cnt_q <= cnt_q - CntW'(1);
                    sh_q  <= dir_left_q ? (sh_q << 1) : (sh_q >> 1);
                end
                StFix: begin
                    out_int_q <= int_fix_c;
                    out_ovf_q <= ovf_fix_c;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_int   = out_int_q;
    assign out_ovf   = out_ovf_q;

endmodule
